systolic_tile_ctrl: RTL
=======================

# systolic_tile_ctrl

Parametrised tile sequencer for an N×N systolic matrix-multiply array. It replaces the fixed 2×2 array controller. On `start` it walks every (A row-tile, W column-tile) pair. For each pair it issues skewed read addresses to the N A-banks and N W-banks, drives per-PE multiply/accumulate enables, and writes each PE's result to its C RAM at the tile's result address. It sits between the UART load FSM (which pulses `start` when loading completes) and the systolic array / RAM banks.

## Interface
- N, 2: array dimension (N A-banks, N W-banks, N×N PEs and C RAMs)
- ADDR_W, 8: A/W bank address width
- C_ADDR_W, 8: C RAM address width
- SEG_W, 7: width of tile-count inputs
- LEN_W, 8: width of segment length
- RAM_LAT, 1: A/W RAM read latency (rden to data at array edge)
- MAC_LAT, 1: cycles from last en_mult to accumulator result valid

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- start  in  1  begin run; sampled only in IDLE
- a_seg_cnt  in  SEG_W  A row-tiles (A height / N)
- w_seg_cnt  in  SEG_W  W column-tiles (W width / N)
- seg_length  in  LEN_W  L = A width = W height
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- err  out  1  illegal parameters on last start; sticky until next accepted start
- a_rden, w_rden  out  N  per-bank read enable
- a_addr, w_addr  out  N*ADDR_W  per-bank address, bank i at bits [i*ADDR_W +: ADDR_W]
- en_mult, clr_accum, c_wren  out  N*N  per-PE, PE(i,j) at bit i*N+j
- c_addr  out  C_ADDR_W  shared C RAM address

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`. `a_seg_cnt`, `w_seg_cnt` and `seg_length` are latched on that cycle; later input changes are ignored.
- Parameter check at `start`. Any of the following sends the block IDLE -> DONE with err=1 and no RAM or PE activity:
  - a_seg_cnt=0, w_seg_cnt=0 or L=0
  - a_seg_cnt·L > 2^ADDR_W
  - w_seg_cnt·L > 2^ADDR_W
  - a_seg_cnt·w_seg_cnt > 2^C_ADDR_W
- Tile order: ta outer (0..a_seg_cnt-1), tw inner (0..w_seg_cnt-1).
- Base addresses are kept in accumulating registers, with no multipliers:
  - a_base = ta·L, w_base = tw·L.
  - c_addr = ta·w_seg_cnt + tw, incremented once per tile.
- Tile period T = L + 2(N-1) + RAM_LAT + MAC_LAT. A cycle counter cyc runs 0..T-1. Within a tile:
  - a_rden[i]=1 for cyc∈[i, i+L-1], a_addr[i] = a_base + (cyc-i). W banks follow the same rule with w_base.
  - en_mult(i,j)=1 for cyc∈[RAM_LAT+i+j, RAM_LAT+i+j+L-1].
  - clr_accum(i,j)=1 only at cyc=RAM_LAT+i+j, together with the first en_mult. This restarts the sum from the first product.
  - c_wren(i,j)=1 only at cyc=RAM_LAT+i+j+L-1+MAC_LAT. c_addr holds the current tile's value through cyc=T-1.
- Tiles run back to back with no overlap: the next tile's cyc=0 follows the current tile's cyc=T-1. The last tile goes to DONE.
- DONE lasts 1 cycle with done=1, then IDLE.
- `start` is ignored in RUN and DONE.
- Outside their active windows, all rden/en/clr/wren outputs are 0 and the address outputs are 0.

## Timing
- Reset values: state IDLE; busy, done, err, all enables, all addresses and c_addr = 0.
- rst asserted mid-run: all outputs are 0 on the next cycle, err is cleared, and no further c_wren is issued.
- busy goes high the cycle after `start` and stays high through the DONE cycle. It is low the cycle after done.
- Valid run latency from `start` to done: a_seg_cnt·w_seg_cnt·T + 1 cycles. Error run: done and err both high the cycle after `start`.
- err updates on each accepted `start` and is stable otherwise.
- Address wrap cannot occur, because the parameter check rejects out-of-range sizes. A run with a_seg_cnt·L = 2^ADDR_W exactly is legal and reaches address 2^ADDR_W-1.

## Test plan
- N=2, RAM_LAT=1, MAC_LAT=1, a_seg=1, w_seg=1, L=3, start at cycle 0 (T=7):
  - a_rden[0] cycles 1-3 with addr 0,1,2; a_rden[1] cycles 2-4.
  - en_mult(0,0) cycles 2-4, en_mult(1,1) cycles 4-6.
  - c_wren(0,0) at cycle 5, c_wren(1,1) at cycle 7, c_addr=0.
  - done at cycle 8; busy low at cycle 9.
- N=2, a_seg=2, w_seg=3, L=4:
  - c_addr sequence 0..5.
  - a_base 0,0,0,4,4,4; w_base 0,4,8,0,4,8.
  - done 6·8+1=49 cycles after start; each PE's c_wren count = 6.
- Parameter errors:
  - L=0 -> done and err at start+1, no rden.
  - a_seg=65, L=4, ADDR_W=8 -> err=1.
  - A following legal start clears err.
- start re-pulsed mid-run and during DONE -> no restart, latency unchanged. New seg_length applied mid-run -> ignored.
- rst asserted at tile 1, cyc 3 -> all outputs 0 next cycle. A fresh start then runs a complete run correctly.
- N=4, a_seg=1, w_seg=1, L=2, RAM_LAT=2, MAC_LAT=3:
  - T=13; en_mult(3,3) cycles 8-9; c_wren(3,3) at cyc 12.
  - Exactly 16 c_wren pulses, each PE once.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an N x N systolic matrix-multiply array.
// Walks every (A row-tile, W column-tile) pair and produces skewed bank reads,
// per-PE multiply/accumulate enables and per-PE C RAM writes for each tile.
module systolic_tile_ctrl #(
  parameter int N        = 2,
  parameter int ADDR_W   = 8,
  parameter int C_ADDR_W = 8,
  parameter int SEG_W    = 7,
  parameter int LEN_W    = 8,
  parameter int RAM_LAT  = 1,
  parameter int MAC_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEG_W-1:0]      a_seg_cnt,
  input  logic [SEG_W-1:0]      w_seg_cnt,
  input  logic [LEN_W-1:0]      seg_length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [N-1:0]          a_rden,
  output logic [N-1:0]          w_rden,
  output logic [N*ADDR_W-1:0]   a_addr,
  output logic [N*ADDR_W-1:0]   w_addr,
  output logic [N*N-1:0]        en_mult,
  output logic [N*N-1:0]        clr_accum,
  output logic [N*N-1:0]        c_wren,
  output logic [C_ADDR_W-1:0]   c_addr
);

  // Fixed part of the tile period: skew across the array plus pipeline latencies.
  localparam int TOFF  = 2 * (N - 1) + RAM_LAT + MAC_LAT;
  localparam int CYC_W = $clog2((1 << LEN_W) + TOFF + 1);

  // Width wide enough for every size product and for the 2^W limits.
  localparam int P1 = SEG_W + LEN_W;
  localparam int P2 = 2 * SEG_W;
  localparam int P3 = ADDR_W + 1;
  localparam int P4 = C_ADDR_W + 1;
  localparam int P12 = (P1 > P2) ? P1 : P2;
  localparam int P34 = (P3 > P4) ? P3 : P4;
  localparam int PW  = (P12 > P34) ? P12 : P34;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [SEG_W-1:0]     a_cnt_q, a_cnt_d, w_cnt_q, w_cnt_d;
  logic [SEG_W-1:0]     ta_q, ta_d, tw_q, tw_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]    a_base_q, a_base_d, w_base_q, w_base_d;
  logic [C_ADDR_W-1:0]  c_addr_q, c_addr_d;
  logic                 err_q, err_d;

  logic                 bad;
  logic [PW-1:0]        prod_al, prod_wl, prod_aw;
  logic [CYC_W-1:0]     len_ext, t_last;
  logic [ADDR_W-1:0]    len_addr;

  // Parameter legality for the values presented with start.
  always_comb begin
    prod_al = PW'(a_seg_cnt) * PW'(seg_length);
    prod_wl = PW'(w_seg_cnt) * PW'(seg_length);
    prod_aw = PW'(a_seg_cnt) * PW'(w_seg_cnt);
    bad = (a_seg_cnt == '0) || (w_seg_cnt == '0) || (seg_length == '0) ||
          (prod_al > (PW'(1) << ADDR_W)) ||
          (prod_wl > (PW'(1) << ADDR_W)) ||
          (prod_aw > (PW'(1) << C_ADDR_W));
  end

  assign len_ext  = CYC_W'(len_q);
  assign t_last   = len_ext + CYC_W'(TOFF - 1);
  assign len_addr = ADDR_W'(len_q);

  // State and run-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      a_cnt_q  <= '0;
      w_cnt_q  <= '0;
      ta_q     <= '0;
      tw_q     <= '0;
      len_q    <= '0;
      a_base_q <= '0;
      w_base_q <= '0;
      c_addr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      a_cnt_q  <= a_cnt_d;
      w_cnt_q  <= w_cnt_d;
      ta_q     <= ta_d;
      tw_q     <= tw_d;
      len_q    <= len_d;
      a_base_q <= a_base_d;
      w_base_q <= w_base_d;
      c_addr_q <= c_addr_d;
      err_q    <= err_d;
    end
  end

  // Next state: tile walk with ta outer, tw inner; bases advance by L per step.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    a_cnt_d  = a_cnt_q;
    w_cnt_d  = w_cnt_q;
    ta_d     = ta_q;
    tw_d     = tw_q;
    len_d    = len_q;
    a_base_d = a_base_q;
    w_base_d = w_base_q;
    c_addr_d = c_addr_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_cnt_d  = a_seg_cnt;
          w_cnt_d  = w_seg_cnt;
          len_d    = seg_length;
          err_d    = bad;
          cyc_d    = '0;
          ta_d     = '0;
          tw_d     = '0;
          a_base_d = '0;
          w_base_d = '0;
          c_addr_d = '0;
          state_d  = bad ? DONE : RUN;
        end
      end
      RUN: begin
        if (cyc_q != t_last) begin
          cyc_d = cyc_q + CYC_W'(1);
        end else begin
          cyc_d = '0;
          if (tw_q != w_cnt_q - SEG_W'(1)) begin
            tw_d     = tw_q + SEG_W'(1);
            w_base_d = w_base_q + len_addr;
            c_addr_d = c_addr_q + C_ADDR_W'(1);
          end else if (ta_q != a_cnt_q - SEG_W'(1)) begin
            tw_d     = '0;
            w_base_d = '0;
            ta_d     = ta_q + SEG_W'(1);
            a_base_d = a_base_q + len_addr;
            c_addr_d = c_addr_q + C_ADDR_W'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: skewed windows relative to the in-tile cycle counter.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = err_q;
    a_rden    = '0;
    w_rden    = '0;
    a_addr    = '0;
    w_addr    = '0;
    en_mult   = '0;
    clr_accum = '0;
    c_wren    = '0;
    c_addr    = '0;
    if (state_q == RUN) begin
      c_addr = c_addr_q;
      for (int unsigned i = 0; i < N; i++) begin
        if (cyc_q >= CYC_W'(i) && cyc_q < CYC_W'(i) + len_ext) begin
          a_rden[i] = 1'b1;
          w_rden[i] = 1'b1;
          a_addr[i*ADDR_W +: ADDR_W] = a_base_q + ADDR_W'(cyc_q - CYC_W'(i));
          w_addr[i*ADDR_W +: ADDR_W] = w_base_q + ADDR_W'(cyc_q - CYC_W'(i));
        end
        for (int unsigned j = 0; j < N; j++) begin
          if (cyc_q >= CYC_W'(RAM_LAT + i + j) &&
              cyc_q < CYC_W'(RAM_LAT + i + j) + len_ext)
            en_mult[i*N + j] = 1'b1;
          if (cyc_q == CYC_W'(RAM_LAT + i + j))
            clr_accum[i*N + j] = 1'b1;
          if (cyc_q == CYC_W'(RAM_LAT + i + j + MAC_LAT - 1) + len_ext)
            c_wren[i*N + j] = 1'b1;
        end
      end
    end
  end

endmodule
